// File: rtl/irq_encoder_8_3_if.sv
// Request/presentation bundle for the 8:3 interrupt priority encoder.
// The master side owns the request lines and the consumer's ready.
// The slave side is the encoder, which drives the code and its status.
interface irq_encoder_8_3_if;
    logic       E;        // request enable
    logic [7:0] d;        // request lines
    logic       ready;    // consumer accepts y when valid is high
    logic [2:0] y;        // presented index
    logic       valid;    // y is meaningful
    logic [7:0] pending;  // sticky pending requests
    logic       lost;     // request hit an already-pending line
    logic       idle;     // nothing pending and nothing presented

    modport master (
        output E, d, ready,
        input  y, valid, pending, lost, idle
    );

    modport slave (
        input  E, d, ready,
        output y, valid, pending, lost, idle
    );
endinterface

// File: rtl/irq_encoder_8_3.sv
// Sequential 8:3 priority encoder.
// Request pulses are collected into a sticky pending register. The index of
// the highest-priority pending line is presented over valid/ready, and that
// line's pending bit clears when the code is accepted. A presented code is
// never pre-empted, and one bubble cycle separates accepted codes.
module irq_encoder_8_3 #(
    parameter int PRIO_MSB_FIRST = 1   // 1: bit 7 wins, 0: bit 0 wins
) (
    input  logic               clk,
    input  logic               rst,    // synchronous, active high
    irq_encoder_8_3_if.slave   bus
);

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    state_t     state_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] y_q;
    logic       valid_q;
    logic       lost_q, lost_d;

    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic [2:0] top_idx;

    // Capture path: set new requests, clear the accepted line; set wins on overlap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        set_mask  = 8'h00;
        clr_mask  = 8'h00;
        if (bus.E) begin
            set_mask = bus.d;
        end
        if (valid_q && bus.ready) begin
            clr_mask = 8'h01 << y_q;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
        // A pulse on the line being cleared this cycle re-arms it and is not a loss.
        lost_d    = |(set_mask & pending_q & ~clr_mask);
    end

    // Highest-priority index of the registered pending vector (this cycle's
    // arrivals are not yet eligible). Later loop hits overwrite earlier ones.
    always_comb begin
        top_idx = 3'd0;
        if (PRIO_MSB_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) top_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) top_idx = 3'(i);
            end
        end
    end

    // Pending/lost registers and the IDLE/PRESENT presentation FSM.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            pending_q <= 8'h00;
            y_q       <= 3'd0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            pending_q <= pending_d;
            lost_q    <= lost_d;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q != 8'h00) begin
                        y_q     <= top_idx;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // y is held until accepted; newer requests never pre-empt it.
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.y       = y_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.lost    = lost_q;
    assign bus.idle    = (pending_q == 8'h00) && !valid_q;

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Self-checking bench for irq_encoder_8_3. Two instances (MSB-first and
// LSB-first priority) share the same stimulus. A vector table and
// hand-written sequences carry explicit expectations; a behavioural model
// tracks both instances through every cycle, including a random phase.
module tb_irq_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic       e_r = 1'b0;
    logic [7:0] d_r = 8'h00;
    logic       rdy_r = 1'b0;

    int total = 0;
    int bad   = 0;

    irq_encoder_8_3_if if_h ();
    irq_encoder_8_3_if if_l ();

    assign if_h.E = e_r;  assign if_h.d = d_r;  assign if_h.ready = rdy_r;
    assign if_l.E = e_r;  assign if_l.d = d_r;  assign if_l.ready = rdy_r;

    irq_encoder_8_3 #(.PRIO_MSB_FIRST(1)) dut_h (.clk(clk), .rst(rst_r), .bus(if_h.slave));
    irq_encoder_8_3 #(.PRIO_MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst_r), .bus(if_l.slave));

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    typedef struct {
        logic [7:0] pend;
        bit         valid;
        logic [2:0] y;
        bit         lost;
    } model_t;

    model_t m_h, m_l;

    function automatic logic [2:0] pick(logic [7:0] p, bit msb_first);
        int b;
        for (int k = 0; k < 8; k++) begin
            b = msb_first ? 7 - k : k;
            if (p[b]) return 3'(b);
        end
        return 3'd0;
    endfunction

    function automatic model_t model_next(model_t m, bit msb_first, bit r, bit e,
                                          logic [7:0] dv, bit rdy);
        model_t     n;
        logic [7:0] req;
        bit         taken;
        n.pend = 8'h00; n.valid = 1'b0; n.y = m.y; n.lost = 1'b0;
        if (r) begin
            n.y = 3'd0;
            return n;
        end
        req   = e ? dv : 8'h00;
        taken = m.valid && rdy;
        n.pend = m.pend;
        for (int i = 0; i < 8; i++) begin
            if (req[i] && m.pend[i] && !(taken && m.y == 3'(i))) n.lost = 1'b1;
        end
        if (taken) n.pend[m.y] = 1'b0;
        n.pend = n.pend | req;
        if (taken) begin
            n.valid = 1'b0;
        end else if (m.valid) begin
            n.valid = 1'b1;
        end else if (m.pend != 8'h00) begin
            n.valid = 1'b1;
            n.y     = pick(m.pend, msb_first);
        end
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_h(input string name, input logic [7:0] p, input bit v,
                           input logic [2:0] y, input bit l);
        check({name, ".pending"}, if_h.pending, p);
        check({name, ".valid"},   8'(if_h.valid), 8'(v));
        if (v) check({name, ".y"}, 8'(if_h.y), 8'(y));
        check({name, ".lost"},    8'(if_h.lost), 8'(l));
        check({name, ".idle"},    8'(if_h.idle), 8'((p == 8'h00) && !v));
    endtask

    task automatic check_model(input string tag, input model_t m, input logic [7:0] p,
                               input logic v, input logic [2:0] y, input logic l,
                               input logic i);
        check({tag, ".pending"}, p, m.pend);
        check({tag, ".valid"},   8'(v), 8'(m.valid));
        if (m.valid) check({tag, ".y"}, 8'(y), 8'(m.y));
        check({tag, ".lost"},    8'(l), 8'(m.lost));
        check({tag, ".idle"},    8'(i), 8'((m.pend == 8'h00) && !m.valid));
    endtask

    // One clock: drive inputs, advance the models, sample #1 after the edge.
    task automatic step(input bit r, input bit e, input logic [7:0] dv, input bit rdy);
        rst_r = r; e_r = e; d_r = dv; rdy_r = rdy;
        m_h = model_next(m_h, 1'b1, r, e, dv, rdy);
        m_l = model_next(m_l, 1'b0, r, e, dv, rdy);
        @(posedge clk);
        #1;
        check_model("model_hi", m_h, if_h.pending, if_h.valid, if_h.y, if_h.lost, if_h.idle);
        check_model("model_lo", m_l, if_l.pending, if_l.valid, if_l.y, if_l.lost, if_l.idle);
    endtask

    // ---------------- vector table (MSB-first instance) ----------------
    typedef struct {
        bit         r;
        bit         e;
        logic [7:0] d;
        bit         rdy;
        logic [7:0] pend;
        bit         v;
        logic [2:0] y;
        bit         l;
    } vec_t;

    vec_t vecs[15];

    initial begin
        m_h = '{pend: 8'h00, valid: 1'b0, y: 3'd0, lost: 1'b0};
        m_l = m_h;

        //          r  e  d      rdy pend   v  y  l
        vecs[0]  = '{1, 1, 8'hFF, 0, 8'h00, 0, 0, 0};  // reset with all lines high
        vecs[1]  = '{1, 1, 8'hFF, 0, 8'h00, 0, 0, 0};
        vecs[2]  = '{0, 1, 8'hFF, 0, 8'hFF, 0, 0, 0};  // first cycle after reset captures
        vecs[3]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[4]  = '{0, 1, 8'h20, 1, 8'h20, 0, 0, 0};  // single request on line 5
        vecs[5]  = '{0, 1, 8'h00, 1, 8'h20, 1, 5, 0};
        vecs[6]  = '{0, 1, 8'h00, 1, 8'h00, 0, 0, 0};
        vecs[7]  = '{0, 1, 8'h00, 1, 8'h00, 0, 0, 0};
        vecs[8]  = '{0, 1, 8'h91, 1, 8'h91, 0, 0, 0};  // priority order 7,4,0
        vecs[9]  = '{0, 1, 8'h00, 1, 8'h91, 1, 7, 0};
        vecs[10] = '{0, 1, 8'h00, 1, 8'h11, 0, 0, 0};
        vecs[11] = '{0, 1, 8'h00, 1, 8'h11, 1, 4, 0};
        vecs[12] = '{0, 1, 8'h00, 1, 8'h01, 0, 0, 0};
        vecs[13] = '{0, 1, 8'h00, 1, 8'h01, 1, 0, 0};
        vecs[14] = '{0, 1, 8'h00, 1, 8'h00, 0, 0, 0};

        for (int k = 0; k < 15; k++) begin
            step(vecs[k].r, vecs[k].e, vecs[k].d, vecs[k].rdy);
            check_h($sformatf("vec%0d", k), vecs[k].pend, vecs[k].v, vecs[k].y, vecs[k].l);
        end

        // Backpressure: y=1 is held while a higher-priority line arrives.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);  check_h("bp_capture", 8'h02, 0, 0, 0);
        step(0, 1, 8'h00, 0);  check_h("bp_present", 8'h02, 1, 1, 0);
        step(0, 1, 8'h80, 0);  check_h("bp_hold0",   8'h82, 1, 1, 0);
        step(0, 1, 8'h00, 0);  check_h("bp_hold1",   8'h82, 1, 1, 0);
        step(0, 1, 8'h00, 0);  check_h("bp_hold2",   8'h82, 1, 1, 0);
        step(0, 1, 8'h00, 1);  check_h("bp_accept",  8'h80, 0, 0, 0);
        step(0, 1, 8'h00, 1);  check_h("bp_next7",   8'h80, 1, 7, 0);
        step(0, 1, 8'h00, 1);  check_h("bp_drain",   8'h00, 0, 0, 0);

        // Lost: repeat pulse on an already-pending line.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h04, 0);  check_h("lost_arm",   8'h04, 0, 0, 0);
        step(0, 1, 8'h04, 0);  check_h("lost_pulse", 8'h04, 1, 2, 1);
        step(0, 1, 8'h00, 0);  check_h("lost_end",   8'h04, 1, 2, 0);
        // Re-arm: pulse lands on the cycle y=2 is accepted.
        step(0, 1, 8'h04, 1);  check_h("rearm_acc",  8'h04, 0, 0, 0);
        step(0, 1, 8'h00, 0);  check_h("rearm_again", 8'h04, 1, 2, 0);
        step(0, 1, 8'h00, 1);  check_h("rearm_done", 8'h00, 0, 0, 0);

        // Enable gating: E=0 blocks capture but presentation continues.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h18, 0);  check_h("en_capture", 8'h18, 0, 0, 0);
        step(0, 0, 8'hFF, 0);  check_h("en_block0",  8'h18, 1, 4, 0);
        step(0, 0, 8'hFF, 1);  check_h("en_block1",  8'h08, 0, 0, 0);
        step(0, 0, 8'hFF, 0);  check_h("en_block2",  8'h08, 1, 3, 0);

        // Reset while presenting y=3 discards it.
        step(1, 0, 8'h00, 0);  check_h("mid_rst",    8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 1);  check_h("mid_rst_after", 8'h00, 0, 0, 0);

        // LSB-first instance: 8'h91 served as 0,4,7.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h91, 1);  check("lo_capture", if_l.pending, 8'h91);
        step(0, 1, 8'h00, 1);  check("lo_y0", 8'({if_l.valid, if_l.y}), 8'h8);
        step(0, 1, 8'h00, 1);  check("lo_pend90", if_l.pending, 8'h90);
        step(0, 1, 8'h00, 1);  check("lo_y4", 8'({if_l.valid, if_l.y}), 8'hC);
        step(0, 1, 8'h00, 1);  check("lo_pend80", if_l.pending, 8'h80);
        step(0, 1, 8'h00, 1);  check("lo_y7", 8'({if_l.valid, if_l.y}), 8'hF);
        step(0, 1, 8'h00, 1);  check("lo_idle", 8'(if_l.idle), 8'h1);

        // Random phase, checked against the model for both priority orders.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) != 0,
                 8'($urandom & $urandom),
                 $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_encoder_8_3.md
Name: irq_encoder_8_3

Overview:
- Sequential 8:3 priority encoder, the encode-side counterpart of the team's 3:8 one-hot decoder.
- Collects request pulses on eight lines into a sticky pending register.
- Presents the 3-bit index of the highest-priority pending line to a consumer over a valid/ready handshake.
- Clears each line's pending bit when its code is accepted. Sits between the request sources and the service/dispatch logic.

Parameters:
- PRIO_MSB_FIRST, default 1: 1 means bit 7 has highest priority; 0 means bit 0 has highest priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- E  input  1  request enable. When 0, d is ignored.
- d  input  8  request lines. Bit i high for one or more cycles requests index i.
- ready  input  1  consumer accepts y this cycle when valid is also 1.
- y  output  3  encoded index of the request being presented. Registered.
- valid  output  1  y is meaningful. Registered.
- pending  output  8  sticky pending request register.
- lost  output  1  one-cycle pulse: a request arrived on a line that was already pending.
- idle  output  1  combinational: pending == 0 and valid == 0.

Behaviour:
- Reset (rst=1 at a rising edge): pending=8'h00, y=3'b000, valid=0, lost=0, FSM=IDLE. Takes priority over all other inputs.
- Reset asserted while in PRESENT: valid is 0 after that edge and the presented request is discarded, not cleared-and-serviced.
- Capture, every cycle:
  - set_mask = E ? d : 8'h00.
  - clr_mask = (valid & ready) ? (8'h01 << y) : 8'h00.
  - pending_next = (pending & ~clr_mask) | set_mask.
  - If the same bit is both set and cleared in one cycle, set wins and the bit stays pending (re-arm).
- lost_next = |(set_mask & pending & ~clr_mask). A pulse on a bit being cleared that cycle is a re-arm, not a loss.
- FSM IDLE:
  - valid=0.
  - If pending != 0: y <= index of highest-priority set bit of the current pending register (per PRIO_MSB_FIRST), valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE.
  - Requests arriving this cycle are not eligible until the next cycle.
- FSM PRESENT:
  - valid=1 and y held stable while ready=0, even if a higher-priority request arrives. There is no pre-emption.
  - On valid & ready: apply clr_mask, valid <= 0, go to IDLE.
  - This forces one bubble cycle between accepted codes, so maximum throughput is one code per 2 cycles.
- Latency:
  - A d pulse at edge n is visible on pending after edge n.
  - valid rises after edge n+1 if the FSM was in IDLE and that bit is the highest-priority pending bit.
- E=0: pending is retained and presentation/acceptance continue normally. Only new captures are blocked.
- All eight lines pending: codes are served strictly in priority order (7,6,...,0 for PRIO_MSB_FIRST=1), each after its own accept.
- ready while valid=0: ignored, no clear.
- y is don't-care for checking while valid=0. RTL holds y at its last value.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with d=8'hFF, E=1. After rst release: pending=00, valid=0, idle=1. d=FF on the first post-reset cycle captures pending=FF.
- Single request: E=1, d=8'h20 for 1 cycle, ready=1 always. Required: pending=20 after 1 cycle; valid=1 with y=5 one cycle later; after accept pending=00, valid=0, idle=1.
- Priority order, PRIO_MSB_FIRST=1: d=8'h91 pulse, ready=1. Required: y sequence 7,4,0, each valid for one cycle separated by one bubble; pending goes 91→11→01→00.
- Backpressure, no pre-emption: d=8'h02, ready=0, wait for valid with y=1; then pulse d=8'h80. Required: y stays 1 with valid=1 until ready=1; next code presented is 7.
- Lost and re-arm:
  - With pending=04 and valid=0, pulse d=04. Required: lost=1 for one cycle and pending stays 04.
  - Pulse d=04 in the same cycle as the accept of y=2. Required: lost=0, pending stays 04, and y=2 is presented again.
- Enable gating and mid-operation reset:
  - E=0 with d=FF. Required: pending unchanged.
  - While valid=1 with y=3, assert rst. Required: valid=0 and pending=00 next cycle.
  - Repeat the priority-order test with PRIO_MSB_FIRST=0 and d=91. Required: y sequence 0,4,7.
